// File: rtl/cflog_flush_arbiter.sv
// rtl/cflog_flush_arbiter.sv - CFLog memory port arbiter and flush streamer
// Monitor writes own the port outright; flush reads slot in around them.
module cflog_flush_arbiter #(
    parameter logic [15:0] LOG_BASE = 16'h0000,
    parameter logic [15:0] LOG_SIZE = 16'h0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mon_wr_en,
    input  logic [15:0] mon_ptr,
    input  logic [15:0] mon_data,
    input  logic        flush_req,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state;
    logic        flush_q;
    logic [15:0] rd_ptr;
    logic [15:0] cnt;
    logic        trig;
    logic [15:0] clamp_ptr;
    logic [16:0] next_ptr;

    assign trig      = flush_req & ~flush_q;
    assign clamp_ptr = ((mon_ptr > LOG_SIZE) ? LOG_SIZE : mon_ptr) & 16'hFFFE;
    // One bit wider so the end-of-log compare cannot wrap
    assign next_ptr  = {1'b0, rd_ptr} + 17'd2;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (mon_wr_en) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = LOG_BASE + mon_ptr;
            mem_wdata = mon_data;
        end else if (state == S_RD) begin
            mem_en    = 1'b1;
            mem_addr  = LOG_BASE + rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            flush_q   <= 1'b0;
            rd_ptr    <= 16'h0000;
            cnt       <= 16'h0000;
            sent_cnt  <= 16'h0000;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else begin
            flush_q <= flush_req;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        cnt      <= clamp_ptr;
                        rd_ptr   <= 16'h0000;
                        sent_cnt <= 16'h0000;
                        state    <= (clamp_ptr == 16'h0000) ? S_DONE : S_RD;
                    end
                end
                S_RD: begin
                    if (!mon_wr_en) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        rd_ptr    <= next_ptr[15:0];
                        sent_cnt  <= sent_cnt + 16'd1;
                        state     <= (next_ptr >= {1'b0, cnt}) ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
